// File: rtl/axi_chan_fifo_bridge_pkg.sv
// Shared AXI4+ATOP channel and bundle types for the per-channel FIFO bridge.
// Channel widths are fixed here so every instance of the bridge agrees on the bundle layout.
package axi_chan_fifo_bridge_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 64;
    localparam int unsigned AXI_ID_WIDTH   = 4;
    localparam int unsigned AXI_USER_WIDTH = 2;
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef logic [AXI_ID_WIDTH-1:0]   id_t;
    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0] data_t;
    typedef logic [AXI_STRB_WIDTH-1:0] strb_t;
    typedef logic [AXI_USER_WIDTH-1:0] user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

endpackage

// File: rtl/axi_chan_fifo_bridge_chan_fifo.sv
// Generic registered FIFO for one AXI channel: no fall-through, ready and valid
// are both registered so neither side has a combinational path to the other.
module chan_fifo #(
    parameter type         T         = logic [7:0],
    parameter int unsigned LOG_DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    input  T     in_data_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output T     out_data_o,
    input  logic out_ready_i
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    typedef logic [LOG_DEPTH-1:0] ptr_t;
    typedef logic [LOG_DEPTH:0]   cnt_t;

    T     mem_q [DEPTH];
    ptr_t wptr_q;
    ptr_t rptr_q;
    cnt_t cnt_q;
    cnt_t cnt_d;
    logic in_ready_q;
    logic out_valid_q;
    logic push;
    logic pop;

    assign push = in_valid_i && in_ready_q;
    assign pop  = out_valid_q && out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    // Flags are registered from the next occupancy, so a pop while full only
    // re-opens ready on the following cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + ptr_t'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + ptr_t'(1);
            end
            cnt_q       <= cnt_d;
            in_ready_q  <= (cnt_d != cnt_t'(DEPTH));
            out_valid_q <= (cnt_d != '0);
        end
    end

    // Storage needs no reset: the head is only observed while valid is high.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= in_data_i;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = mem_q[rptr_q];

endmodule

// File: rtl/axi_chan_fifo_bridge.sv
// AXI4+ATOP decoupling bridge: each of AW, W, AR (towards dst) and B, R
// (towards src) runs through its own independent chan_fifo.
module axi_chan_fifo_bridge
    import axi_chan_fifo_bridge_pkg::*;
#(
    parameter int unsigned LOG_DEPTH = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  src_req_i,
    output resp_t src_resp_o,
    output req_t  dst_req_o,
    input  resp_t dst_resp_i
);

    aw_chan_t aw_out;
    w_chan_t  w_out;
    ar_chan_t ar_out;
    b_chan_t  b_out;
    r_chan_t  r_out;
    logic     aw_out_valid, w_out_valid, ar_out_valid, b_out_valid, r_out_valid;
    logic     aw_in_ready, w_in_ready, ar_in_ready, b_in_ready, r_in_ready;

    chan_fifo #(.T(aw_chan_t), .LOG_DEPTH(LOG_DEPTH)) i_aw_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (src_req_i.aw_valid),
        .in_data_i   (src_req_i.aw),
        .in_ready_o  (aw_in_ready),
        .out_valid_o (aw_out_valid),
        .out_data_o  (aw_out),
        .out_ready_i (dst_resp_i.aw_ready)
    );

    chan_fifo #(.T(w_chan_t), .LOG_DEPTH(LOG_DEPTH)) i_w_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (src_req_i.w_valid),
        .in_data_i   (src_req_i.w),
        .in_ready_o  (w_in_ready),
        .out_valid_o (w_out_valid),
        .out_data_o  (w_out),
        .out_ready_i (dst_resp_i.w_ready)
    );

    chan_fifo #(.T(ar_chan_t), .LOG_DEPTH(LOG_DEPTH)) i_ar_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (src_req_i.ar_valid),
        .in_data_i   (src_req_i.ar),
        .in_ready_o  (ar_in_ready),
        .out_valid_o (ar_out_valid),
        .out_data_o  (ar_out),
        .out_ready_i (dst_resp_i.ar_ready)
    );

    chan_fifo #(.T(b_chan_t), .LOG_DEPTH(LOG_DEPTH)) i_b_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (dst_resp_i.b_valid),
        .in_data_i   (dst_resp_i.b),
        .in_ready_o  (b_in_ready),
        .out_valid_o (b_out_valid),
        .out_data_o  (b_out),
        .out_ready_i (src_req_i.b_ready)
    );

    chan_fifo #(.T(r_chan_t), .LOG_DEPTH(LOG_DEPTH)) i_r_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (dst_resp_i.r_valid),
        .in_data_i   (dst_resp_i.r),
        .in_ready_o  (r_in_ready),
        .out_valid_o (r_out_valid),
        .out_data_o  (r_out),
        .out_ready_i (src_req_i.r_ready)
    );

    always_comb begin
        dst_req_o          = '0;
        dst_req_o.aw       = aw_out;
        dst_req_o.aw_valid = aw_out_valid;
        dst_req_o.w        = w_out;
        dst_req_o.w_valid  = w_out_valid;
        dst_req_o.ar       = ar_out;
        dst_req_o.ar_valid = ar_out_valid;
        dst_req_o.b_ready  = b_in_ready;
        dst_req_o.r_ready  = r_in_ready;

        src_resp_o          = '0;
        src_resp_o.aw_ready = aw_in_ready;
        src_resp_o.w_ready  = w_in_ready;
        src_resp_o.ar_ready = ar_in_ready;
        src_resp_o.b        = b_out;
        src_resp_o.b_valid  = b_out_valid;
        src_resp_o.r        = r_out;
        src_resp_o.r_valid  = r_out_valid;
    end

endmodule

// File: tb/tb_axi_chan_fifo_bridge.sv
// Bench for axi_chan_fifo_bridge: queue-based channel model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_axi_chan_fifo_bridge;
    import axi_chan_fifo_bridge_pkg::*;

    localparam int LOG_DEPTH = 2;
    localparam int DEPTH     = 1 << LOG_DEPTH;
    localparam int AWB = $bits(aw_chan_t);
    localparam int WB  = $bits(w_chan_t);
    localparam int ARB = $bits(ar_chan_t);
    localparam int BB  = $bits(b_chan_t);
    localparam int RB  = $bits(r_chan_t);
    localparam int NTX = 500;

    logic  clk;
    logic  rst;
    req_t  src_req;
    resp_t src_resp;
    req_t  dst_req;
    resp_t dst_resp;

    axi_chan_fifo_bridge #(.LOG_DEPTH(LOG_DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .src_req_i  (src_req),
        .src_resp_o (src_resp),
        .dst_req_o  (dst_req),
        .dst_resp_i (dst_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] aw2v(input aw_chan_t x); return {{(128-AWB){1'b0}}, x}; endfunction
    function automatic logic [127:0] w2v (input w_chan_t  x); return {{(128-WB){1'b0}},  x}; endfunction
    function automatic logic [127:0] ar2v(input ar_chan_t x); return {{(128-ARB){1'b0}}, x}; endfunction
    function automatic logic [127:0] b2v (input b_chan_t  x); return {{(128-BB){1'b0}},  x}; endfunction
    function automatic logic [127:0] r2v (input r_chan_t  x); return {{(128-RB){1'b0}},  x}; endfunction

    // Channel index: 0 AW, 1 W, 2 AR (src->dst), 3 B, 4 R (dst->src).
    string        chn [5] = '{"AW", "W", "AR", "B", "R"};
    logic         drv_valid  [5];
    logic [127:0] drv_pay    [5];
    logic         drv_oready [5];
    logic         inr  [5];
    logic         outv [5];
    logic [127:0] outp [5];

    always_comb begin
        src_req          = '0;
        src_req.aw       = aw_chan_t'(drv_pay[0][AWB-1:0]);
        src_req.aw_valid = drv_valid[0];
        src_req.w        = w_chan_t'(drv_pay[1][WB-1:0]);
        src_req.w_valid  = drv_valid[1];
        src_req.ar       = ar_chan_t'(drv_pay[2][ARB-1:0]);
        src_req.ar_valid = drv_valid[2];
        src_req.b_ready  = drv_oready[3];
        src_req.r_ready  = drv_oready[4];
        dst_resp          = '0;
        dst_resp.aw_ready = drv_oready[0];
        dst_resp.w_ready  = drv_oready[1];
        dst_resp.ar_ready = drv_oready[2];
        dst_resp.b        = b_chan_t'(drv_pay[3][BB-1:0]);
        dst_resp.b_valid  = drv_valid[3];
        dst_resp.r        = r_chan_t'(drv_pay[4][RB-1:0]);
        dst_resp.r_valid  = drv_valid[4];
    end

    assign inr[0] = src_resp.aw_ready;  assign outv[0] = dst_req.aw_valid;  assign outp[0] = aw2v(dst_req.aw);
    assign inr[1] = src_resp.w_ready;   assign outv[1] = dst_req.w_valid;   assign outp[1] = w2v(dst_req.w);
    assign inr[2] = src_resp.ar_ready;  assign outv[2] = dst_req.ar_valid;  assign outp[2] = ar2v(dst_req.ar);
    assign inr[3] = dst_req.b_ready;    assign outv[3] = src_resp.b_valid;  assign outp[3] = b2v(src_resp.b);
    assign inr[4] = dst_req.r_ready;    assign outv[4] = src_resp.r_valid;  assign outp[4] = r2v(src_resp.r);

    // Behavioural model: each channel is an ordered queue of at most DEPTH beats.
    logic [127:0] mq   [5][$];
    logic [127:0] olog [5][$];
    logic         hs_in  [5];
    logic         hs_out [5];
    int           ocount [5];
    int           rlast;
    logic         m_live = 1'b0;
    logic         m_started = 1'b0;
    int           mn;
    logic         mpush, mpop;

    initial begin
        rlast = 0;
        for (int c = 0; c < 5; c++) begin
            ocount[c] = 0;
            hs_in[c]  = 1'b0;
            hs_out[c] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < 5; c++) begin
            hs_in[c]  = drv_valid[c] && inr[c];
            hs_out[c] = outv[c] && drv_oready[c];
            if (hs_out[c]) begin
                olog[c].push_back(outp[c]);
                ocount[c]++;
            end
        end
        if (hs_out[4] && src_resp.r.last) rlast++;
        if (rst) begin
            for (int c = 0; c < 5; c++) mq[c].delete();
            m_live    = 1'b0;
            m_started = 1'b1;
        end else begin
            for (int c = 0; c < 5; c++) begin
                mn    = mq[c].size();
                mpush = drv_valid[c] && m_live && (mn < DEPTH);
                mpop  = (mn != 0) && drv_oready[c];
                if (mpop)  void'(mq[c].pop_front());
                if (mpush) mq[c].push_back(drv_pay[c]);
            end
            m_live = 1'b1;
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic cmp_all();
        for (int c = 0; c < 5; c++) begin
            check({chn[c], "_in_ready"}, inr[c], m_live && (mq[c].size() < DEPTH));
            check({chn[c], "_out_valid"}, outv[c], mq[c].size() != 0);
            if (mq[c].size() != 0) check({chn[c], "_payload"}, outp[c], mq[c][0]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_started) cmp_all();
    endtask

    logic [127:0] stream [5][$];
    int           pidx  [5];
    int           pwait [5];
    int           cwait [5];
    int           base  [5];

    function automatic int rwait();
        return ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 10));
    endfunction

    initial begin
        aw_chan_t     aw;
        w_chan_t      w;
        ar_chan_t     ar;
        b_chan_t      b;
        r_chan_t      r;
        logic [127:0] rnd;
        int           lb, bbase, rbase, cyc;
        logic         done;

        for (int c = 0; c < 5; c++) begin
            drv_valid[c] = 1'b0; drv_pay[c] = '0; drv_oready[c] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check({chn[c], "_post_reset_ready"}, inr[c], 1'b1);
            check({chn[c], "_post_reset_valid"}, outv[c], 1'b0);
        end

        // Single write with its B response.
        aw = '0; aw.id = 4'd3; aw.addr = 32'h1000; aw.len = 8'd0; aw.size = 3'd3; aw.burst = BURST_INCR;
        w = '0; w.data = 64'hDEAD_BEEF_CAFE_F00D; w.strb = 8'hFF; w.last = 1'b1;
        drv_pay[0] = aw2v(aw); drv_valid[0] = 1'b1;
        drv_pay[1] = w2v(w);   drv_valid[1] = 1'b1;
        check("t1_aw_valid_before", outv[0], 1'b0);
        check("t1_w_valid_before", outv[1], 1'b0);
        tick();
        drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
        check("t1_aw_valid", outv[0], 1'b1);
        check("t1_aw_addr", dst_req.aw.addr, 32'h1000);
        check("t1_aw_id", dst_req.aw.id, 4'd3);
        check("t1_aw_len", dst_req.aw.len, 8'd0);
        check("t1_w_valid", outv[1], 1'b1);
        check("t1_w_data", dst_req.w.data, 64'hDEAD_BEEF_CAFE_F00D);
        check("t1_w_strb", dst_req.w.strb, 8'hFF);
        check("t1_w_last", dst_req.w.last, 1'b1);
        drv_oready[0] = 1'b1; drv_oready[1] = 1'b1;
        b = '0; b.id = 4'd3; b.resp = RESP_OKAY;
        drv_pay[3] = b2v(b); drv_valid[3] = 1'b1; drv_oready[3] = 1'b1;
        check("t1_b_valid_before", outv[3], 1'b0);
        tick();
        drv_valid[3] = 1'b0; drv_oready[0] = 1'b0; drv_oready[1] = 1'b0;
        check("t1_b_valid", src_resp.b_valid, 1'b1);
        check("t1_b_id", src_resp.b.id, 4'd3);
        check("t1_b_resp", src_resp.b.resp, RESP_OKAY);
        tick();
        drv_oready[3] = 1'b0;

        // Fill the AW FIFO against a stalled destination, then drain.
        lb = olog[0].size();
        for (int i = 0; i < 4; i++) begin
            aw = '0; aw.addr = 32'(i * 16);
            drv_pay[0] = aw2v(aw); drv_valid[0] = 1'b1;
            check("t2_ready_while_filling", inr[0], 1'b1);
            tick();
        end
        drv_valid[0] = 1'b0;
        check("t2_full_ready", inr[0], 1'b0);
        drv_oready[0] = 1'b1;
        tick();
        check("t2_ready_after_pop", inr[0], 1'b1);
        repeat (4) tick();
        drv_oready[0] = 1'b0;
        check("t2_drain_count", olog[0].size() - lb, 4);
        for (int k = 0; k < 4 && lb + k < olog[0].size(); k++) begin
            aw = aw_chan_t'(olog[0][lb + k][AWB-1:0]);
            check("t2_order_addr", aw.addr, 32'(k * 16));
        end

        // R stream with two beats parked: push and pop together every cycle.
        lb = olog[4].size();
        for (int i = 0; i < 16; i++) begin
            r = '0; r.id = 4'd5; r.data = 64'(i); r.last = (i == 15);
            drv_pay[4] = r2v(r); drv_valid[4] = 1'b1;
            if (i == 2) drv_oready[4] = 1'b1;
            if (i >= 2) begin
                check("t3_dst_r_ready", inr[4], 1'b1);
                check("t3_src_r_valid", outv[4], 1'b1);
            end
            tick();
        end
        drv_valid[4] = 1'b0;
        repeat (3) tick();
        drv_oready[4] = 1'b0;
        check("t3_beat_count", olog[4].size() - lb, 16);
        for (int k = 0; k < 16 && lb + k < olog[4].size(); k++) begin
            r = r_chan_t'(olog[4][lb + k][RB-1:0]);
            check("t3_r_data", r.data, 64'(k));
            check("t3_r_last", r.last, k == 15);
        end

        // Reset with W beats parked.
        for (int i = 0; i < 3; i++) begin
            w = '0; w.data = {$urandom, $urandom}; w.strb = 8'hA5; w.last = (i == 2);
            drv_pay[1] = w2v(w); drv_valid[1] = 1'b1;
            tick();
        end
        drv_valid[1] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check({chn[c], "_rst_ready"}, inr[c], 1'b0);
            check({chn[c], "_rst_valid"}, outv[c], 1'b0);
        end
        lb = olog[1].size();
        drv_oready[1] = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) check({chn[c], "_release_ready"}, inr[c], 1'b1);
        repeat (4) tick();
        drv_oready[1] = 1'b0;
        check("t4_no_stale_w", olog[1].size() - lb, 0);

        // Random soak: independent per-channel streams with random gaps both sides.
        for (int n = 0; n < NTX; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            aw = aw_chan_t'(rnd[AWB-1:0]); aw.len = 8'($urandom_range(0, 15));
            stream[0].push_back(aw2v(aw));
            for (int k = 0; k <= int'(aw.len); k++) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                w = w_chan_t'(rnd[WB-1:0]); w.last = (k == int'(aw.len));
                stream[1].push_back(w2v(w));
            end
            rnd = {$urandom, $urandom, $urandom, $urandom};
            b = b_chan_t'(rnd[BB-1:0]); b.id = aw.id;
            stream[3].push_back(b2v(b));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            ar = ar_chan_t'(rnd[ARB-1:0]); ar.len = 8'($urandom_range(0, 15));
            stream[2].push_back(ar2v(ar));
            for (int k = 0; k <= int'(ar.len); k++) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                r = r_chan_t'(rnd[RB-1:0]); r.id = ar.id; r.last = (k == int'(ar.len));
                stream[4].push_back(r2v(r));
            end
        end
        for (int c = 0; c < 5; c++) begin
            pidx[c] = 0; pwait[c] = 0; cwait[c] = 0; base[c] = ocount[c];
        end
        bbase = ocount[3];
        rbase = rlast;
        cyc   = 0;
        done  = 1'b0;
        while (!done && cyc < 60000) begin
            tick();
            for (int c = 0; c < 5; c++) begin
                if (drv_valid[c] && hs_in[c]) begin
                    pidx[c]++;
                    drv_valid[c] = 1'b0;
                    pwait[c] = rwait();
                end
                if (!drv_valid[c]) begin
                    if (pwait[c] != 0) pwait[c]--;
                    else if (pidx[c] < stream[c].size()) begin
                        drv_valid[c] = 1'b1;
                        drv_pay[c]   = stream[c][pidx[c]];
                    end
                end
                if (hs_out[c]) cwait[c] = rwait();
                if (cwait[c] != 0) begin
                    drv_oready[c] = 1'b0;
                    cwait[c]--;
                end else begin
                    drv_oready[c] = 1'b1;
                end
            end
            done = 1'b1;
            for (int c = 0; c < 5; c++)
                if (ocount[c] - base[c] != stream[c].size()) done = 1'b0;
            cyc++;
        end
        check("soak_completed_in_budget", done, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check({chn[c], "_soak_beats"}, ocount[c] - base[c], stream[c].size());
            check({chn[c], "_soak_residual"}, mq[c].size(), 0);
        end
        check("soak_b_count", ocount[3] - bbase, NTX);
        check("soak_r_last_count", rlast - rbase, NTX);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/axi_chan_fifo_bridge.md
Name: axi_chan_fifo_bridge

Overview:
Single-clock AXI4+ATOP decoupling bridge between an upstream master port (src) and a downstream slave port (dst). Each of the five channels (AW, W, AR towards dst; B, R towards src) passes through its own FIFO of depth 2**LOG_DEPTH. Payloads are bit-exact and in order per channel, and no transaction is created, dropped or altered. It sits between interconnect stages to break valid/ready combinational paths and absorb bursty traffic.

Parameters:
AXI_ADDR_WIDTH, 32, address width of AW/AR addr.
AXI_DATA_WIDTH, 64, R/W data width; strb width is AXI_DATA_WIDTH/8.
AXI_ID_WIDTH, 4, ID width on AW/AR/B/R.
AXI_USER_WIDTH, 2, user width on all channels.
LOG_DEPTH, 2, log2 of per-channel FIFO depth; must be >=1, so depth 4 by default.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
src_req_i  in  req_t  upstream AW/W/AR valid+payload, b_ready, r_ready.
src_resp_o  out  resp_t  upstream aw/w/ar_ready, B/R valid+payload.
dst_req_o  out  req_t  downstream AW/W/AR valid+payload, b_ready, r_ready.
dst_resp_i  in  resp_t  downstream aw/w/ar_ready, B/R valid+payload.
Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Channel payloads:
  - AW: id, addr, len[8], size[3], burst[2], lock, cache[4], prot[3], qos[4], region[4], atop[6], user.
  - AR: same as AW without atop.
  - W: data, strb, last, user.
  - B: id, resp[2], user.
  - R: id, data, resp[2], last, user.
- Each channel uses an identical FIFO: input side takes valid/payload and drives ready; output side drives valid/payload and takes ready.
- Input ready = !full. Push happens when valid&&ready at the clock edge.
- Output valid = !empty. Payload = head entry, driven from registers with no combinational path from input to output. Pop happens when valid&&ready.
- Latency: a beat pushed at edge N is visible at the output after edge N, so it can complete at edge N+1 at the earliest. Minimum 1 cycle, no fall-through.
- Full: ready=0. A simultaneous pop does not re-enable ready in the same cycle, so ready has no combinational dependence on output ready.
- Empty: valid=0, and the payload value is don't-care.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged; the order of the two operations is irrelevant to the result.
- Read/write pointers are LOG_DEPTH bits and wrap modulo depth. Full/empty are decided by an occupancy counter of LOG_DEPTH+1 bits.
- Once an output valid is asserted, it and its payload stay stable until handshaked (AXI compliant).
- Channels are fully independent: no AW/W ordering coupling and no ID-based reordering. Per-channel FIFO order is preserved.
- While rst_i=1 at an edge:
  - all FIFOs are emptied;
  - all output valids=0 and all input readies=0 in the following cycle.
- Beats in flight when reset asserts mid-operation are discarded, and no partial state is kept.
- First cycle after reset release: all readies=1, all valids=0.

Decomposition:
- Package axi_chan_fifo_bridge_pkg holds:
  - the aw/w/b/ar/r channel structs;
  - the req_t/resp_t structs;
  - burst/resp encodings.
- One sub-module, chan_fifo, is generic over a payload type and LOG_DEPTH, and is instantiated five times.

Test Plan:
- Single write: AW id=3 addr=0x1000 len=0, W data=0xDEADBEEF_CAFEF00D strb=0xFF last=1, dst B id=3 resp=OKAY. Required: identical AW/W at dst, with dst valids rising exactly 1 cycle after the src handshake; B id=3 OKAY returned to src.
- Fill: dst aw_ready=0, push 4 AWs addr 0x0/0x10/0x20/0x30. Required: src aw_ready=0 after the 4th. Release dst ready: dst sees the 4 AWs in order, and src aw_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop on R with 2 beats queued: src r_ready=1 and a dst R beat every cycle for 16 beats (len=15, last on beat 16). Required: occupancy stays 2, r_ready never drops, and all 16 beats arrive in order with last only on beat 16.
- Reset mid-operation: 3 W beats queued, assert rst_i one cycle. Required: next cycle all valids=0 and readies=0. After release, no stale W beat appears at dst.
- Random soak: 500 reads + 500 writes, bursts up to 16, random 0-10 cycle waits on both sides. Required: per-channel scoreboard matches bit-exact, and B/R counts equal 500 each.
